classificador_eventos_botao: RTL and testbench

Button event classifier that sits directly downstream of the button debouncer/controller. It consumes the clean, clock-synchronous button level and turns each press into exactly one one-cycle event pulse: short press, long press, or (optionally) double press. It also drives a "held" level for the duration of a long press. The Tamagotchi menu and action logic consume these events instead of raw button levels.

---
 rtl/classificador_eventos_botao.sv | 116 +++++++++++
 tb/tb_classificador_eventos_botao.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/classificador_eventos_botao.sv
// Button event classifier: turns a debounced button level into short/long/double press pulses.
// Optional double-press detection is enabled by defining DOUBLE_CLICK_EN.
module classificador_eventos_botao #(
   parameter int unsigned LONG_CYCLES = 50000,
   parameter int unsigned GAP_CYCLES  = 15000,
   parameter int unsigned CNT_W       = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic b_in,
   output logic short_press,
   output logic long_press,
   output logic double_press,
   output logic held
);

   typedef enum logic [2:0] {
      RELEASE_WAIT, IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef DOUBLE_CLICK_EN
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             short_d, long_d, double_d, held_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RELEASE_WAIT;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         RELEASE_WAIT: if (!b_in) state_n = IDLE;
         IDLE:         if (b_in) state_n = PRESSED;
         PRESSED: begin
            if (b_in) begin
               if (cnt == LONG_LAST) state_n = LONG_HELD;
               else                  cnt_n   = cnt + 1'b1;
            end else begin
`ifdef DOUBLE_CLICK_EN
               state_n = WAIT_SECOND;
`else
               state_n = IDLE;
`endif
            end
         end
         LONG_HELD:    if (!b_in) state_n = IDLE;
`ifdef DOUBLE_CLICK_EN
         // A re-press on the timeout edge still counts as the second press.
         WAIT_SECOND: begin
            if (b_in)                 state_n = SECOND_PRESSED;
            else if (cnt == GAP_LAST) state_n = IDLE;
            else                      cnt_n   = cnt + 1'b1;
         end
         SECOND_PRESSED: if (!b_in) state_n = IDLE;
`endif
         default:      state_n = RELEASE_WAIT;
      endcase
      if (state_n != state) cnt_n = '0;
   end

   always_comb begin
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;
      case (state)
         PRESSED: begin
            long_d = b_in && (cnt == LONG_LAST);
`ifndef DOUBLE_CLICK_EN
            short_d = !b_in;
`endif
         end
`ifdef DOUBLE_CLICK_EN
         WAIT_SECOND:    short_d  = !b_in && (cnt == GAP_LAST);
         SECOND_PRESSED: double_d = !b_in;
`endif
         default: ;
      endcase
      held_d = (state_n == LONG_HELD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         short_press <= 1'b0;
         long_press  <= 1'b0;
         held        <= 1'b0;
      end else begin
         short_press <= short_d;
         long_press  <= long_d;
         held        <= held_d;
      end
   end

`ifdef DOUBLE_CLICK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) double_press <= 1'b0;
      else     double_press <= double_d;
   end
`else
   assign double_press = 1'b0;
   logic unused_dbl;
   assign unused_dbl = double_d;
`endif

endmodule

// File: tb/tb_classificador_eventos_botao.sv
// Randomized + directed bench for classificador_eventos_botao against an edge-index reference model.
module tb_classificador_eventos_botao;

   localparam int LONG = 8;
   localparam int GAP  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic b_in = 1'b0;
   logic short_press, long_press, double_press, held;

   int tests = 0;
   int fails = 0;

   classificador_eventos_botao #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .b_in(b_in),
      .short_press(short_press), .long_press(long_press),
      .double_press(double_press), .held(held)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: tracks press/release edge indices and decides events by duration arithmetic.
   int  t = 0, start_t = 0, rel_t = 0;
   bit  blocked = 1, in_press = 0, in_long = 0, in_gap = 0, in_second = 0;
   bit  es, el, ed, eh;
   int  n_s, n_l, n_d;
   bit  rst_next = 1'b1;

   task automatic model_reset();
      blocked = 1; in_press = 0; in_long = 0; in_gap = 0; in_second = 0;
      es = 0; el = 0; ed = 0; eh = 0;
   endtask

   task automatic model_step(input bit b);
      es = 0; el = 0; ed = 0;
      t++;
      if (blocked) begin
         if (!b) blocked = 0;
      end else if (in_long) begin
         if (!b) in_long = 0;
      end else if (in_press) begin
         if (b && (t - start_t == LONG)) begin
            el = 1; in_press = 0; in_long = 1;
         end else if (!b) begin
            in_press = 0;
`ifdef DOUBLE_CLICK_EN
            rel_t = t; in_gap = 1;
`else
            es = 1;
`endif
         end
      end else if (in_gap) begin
         if (b) begin in_gap = 0; in_second = 1; end
         else if (t - rel_t == GAP) begin es = 1; in_gap = 0; end
      end else if (in_second) begin
         if (!b) begin ed = 1; in_second = 0; end
      end else if (b) begin
         in_press = 1; start_t = t;
      end
      eh = in_long;
   endtask

   task automatic step(input bit b);
      @(negedge clk);
      b_in = b;
      rst  = rst_next;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(b);
      #1;
      chk("short_press", short_press, es);
      chk("long_press", long_press, el);
      chk("double_press", double_press, ed);
      chk("held", held, eh);
      n_s += short_press; n_l += long_press; n_d += double_press;
   endtask

   task automatic run(input bit b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   // Asserted mid-cycle so the asynchronous clear is observable before any edge.
   task automatic pulse_reset(input int n);
      @(negedge clk);
      #1 rst = 1'b1;
      rst_next = 1'b1;
      #1;
      chk("rst_async_short", short_press, 0);
      chk("rst_async_long", long_press, 0);
      chk("rst_async_double", double_press, 0);
      chk("rst_async_held", held, 0);
      model_reset();
      run(b_in, n);
      rst_next = 1'b0;
   endtask

   task automatic clr();
      n_s = 0; n_l = 0; n_d = 0;
   endtask

   initial begin
      model_reset();
      #2;
      chk("reset_short", short_press, 0);
      chk("reset_held", held, 0);
      run(0, 2);
      rst_next = 1'b0;

      // Short press of 3 edges
      clr(); run(0, 2); run(1, 3); run(0, 8);
      chk("s1_short_cnt", n_s, 1);
      chk("s1_long_cnt", n_l, 0);

      // Long press of 20 edges
      clr(); run(1, 20); run(0, 8);
      chk("s2_long_cnt", n_l, 1);
      chk("s2_short_cnt", n_s, 0);
      chk("s2_double_cnt", n_d, 0);

      // Two quick presses
      clr(); run(1, 2); run(0, 2); run(1, 2); run(0, 8);
`ifdef DOUBLE_CLICK_EN
      chk("s3_double_cnt", n_d, 1);
      chk("s3_short_cnt", n_s, 0);
`else
      chk("s3_double_cnt", n_d, 0);
      chk("s3_short_cnt", n_s, 2);
`endif

      // Re-press exactly at release + GAP
      clr(); run(1, 2); run(0, 1); run(0, 3); run(1, 1); run(0, 8);
`ifdef DOUBLE_CLICK_EN
      chk("s4_double_cnt", n_d, 1);
      chk("s4_short_cnt", n_s, 0);
`else
      chk("s4_short_cnt", n_s, 2);
`endif

      // Button held across reset
      run(1, 1); pulse_reset(3);
      clr(); run(1, 10);
      chk("s5_no_events", n_s + n_l + n_d, 0);
      run(0, 1); run(1, 2); run(0, 8);
      chk("s5_short_after", n_s, 1);

      // Reset 5 edges into a press
      run(1, 5); pulse_reset(2);
      clr(); run(1, 3); run(0, 8);
      chk("s6_no_events", n_s + n_l + n_d, 0);

      // Random runs of high/low with occasional resets
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
         run(1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end
      run(0, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
